// File: rtl/axi_r_responder.sv
// axi_r_responder
//   Slave-side AXI read responder that drives the R channel. It accepts one
//   AR request at a time. For each beat it issues a single read to a
//   1-cycle-latency synchronous memory and returns the data as one R beat.
//   The beat addresses follow the FIXED, INCR or WRAP burst rules.
//   An illegal request reads no memory. It answers with len+1 SLVERR beats.
//
// Ports
//   clk, nrst              clock (rising edge), asynchronous active-low reset
//   AR*                    read address channel (ARID/ARADDR/ARLEN/ARSIZE/
//                          ARBURST/ARVALID in, ARREADY out)
//   R*                     read data channel (RID/RDATA/RRESP/RLAST/RVALID
//                          out, RREADY in)
//   mem_re/mem_addr        memory read strobe and byte address
//   mem_rdata              memory data, valid the cycle after mem_re
module axi_r_responder #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic [ID_WIDTH-1:0]   ARID,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [2:0]            ARSIZE,
    input  logic [1:0]            ARBURST,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [ID_WIDTH-1:0]   RID,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    // Largest legal ARSIZE: a beat may not be wider than the data bus.
    localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, READ, CAPT, RESP, ERESP} state_t;

    state_t                state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [7:0]            cnt;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] span;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic                  illegal;

    // Address of the following beat. For WRAP the low bits advance inside the
    // span-aligned window and the high bits stay fixed. A legal WRAP has
    // len+1 in {2,4,8,16}, so span is always a power of two.
    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size_q;
        span      = (ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q;
        incr      = addr_q + bytes;
        next_addr = addr_q;
        case (burst_q)
            2'b01:   next_addr = incr;
            2'b10:   next_addr = (addr_q & ~(span - ADDR_WIDTH'(1))) |
                                 (incr & (span - ADDR_WIDTH'(1)));
            default: next_addr = addr_q;
        endcase
    end

    assign illegal = (ARBURST == 2'b11) || (ARSIZE > MAX_SIZE) ||
                     ((ARBURST == 2'b10) &&
                      !(ARLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b0;
            RLAST    <= 1'b0;
            RID      <= '0;
            RDATA    <= '0;
            RRESP    <= 2'b00;
            mem_re   <= 1'b0;
            mem_addr <= '0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            cnt      <= '0;
            size_q   <= '0;
            burst_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ARREADY <= 1'b1;
                    if (ARVALID && ARREADY) begin
                        ARREADY <= 1'b0;
                        id_q    <= ARID;
                        addr_q  <= ARADDR;
                        len_q   <= ARLEN;
                        size_q  <= ARSIZE;
                        burst_q <= ARBURST;
                        cnt     <= '0;
                        if (illegal) begin
                            // The first error beat is presented right away.
                            state  <= ERESP;
                            RVALID <= 1'b1;
                            RRESP  <= 2'b10;
                            RDATA  <= '0;
                            RID    <= ARID;
                            RLAST  <= (ARLEN == 8'd0);
                        end else begin
                            state    <= READ;
                            mem_re   <= 1'b1;
                            mem_addr <= ARADDR;
                        end
                    end
                end
                READ: begin
                    mem_re <= 1'b0;
                    state  <= CAPT;
                end
                CAPT: begin
                    RDATA  <= mem_rdata;
                    RRESP  <= 2'b00;
                    RID    <= id_q;
                    RLAST  <= (cnt == len_q);
                    RVALID <= 1'b1;
                    state  <= RESP;
                end
                RESP: begin
                    if (RREADY) begin
                        RVALID <= 1'b0;
                        if (RLAST) begin
                            state   <= IDLE;
                            ARREADY <= 1'b1;
                        end else begin
                            // The counter stops at len, so ARLEN=255 never wraps it.
                            cnt      <= cnt + 8'd1;
                            addr_q   <= next_addr;
                            mem_addr <= next_addr;
                            mem_re   <= 1'b1;
                            state    <= READ;
                        end
                    end
                end
                ERESP: begin
                    // RVALID alternates. A beat is raised when RVALID is low.
                    // It drops for one cycle after each handshake.
                    if (!RVALID) begin
                        RVALID <= 1'b1;
                        RLAST  <= (cnt == len_q);
                    end else if (RREADY) begin
                        RVALID <= 1'b0;
                        if (RLAST) begin
                            state   <= IDLE;
                            ARREADY <= 1'b1;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_r_responder.sv
// tb_axi_r_responder
//   Self-checking bench for axi_r_responder. A table of directed bursts is
//   followed by a mid-burst reset sequence and then randomized bursts.
//   Beat addresses are checked against a closed-form address model.
//   Read data is checked against a fixed data function of the address.
//   Inputs are driven and outputs sampled on the falling edge.
module tb_axi_r_responder;
    localparam int IW = 4;
    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [IW-1:0] ARID;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic [2:0]    ARSIZE;
    logic [1:0]    ARBURST;
    logic          ARVALID;
    logic          ARREADY;
    logic [IW-1:0] RID;
    logic [DW-1:0] RDATA;
    logic [1:0]    RRESP;
    logic          RLAST;
    logic          RVALID;
    logic          RREADY;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata = '0;

    axi_r_responder #(.ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .nrst(nrst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // The memory contents are a fixed function of the byte address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] r;
        r = (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
        return r;
    endfunction

    always @(posedge clk) if (mem_re) mem_rdata <= memf(mem_addr);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Address of beat i, computed directly from the start address.
    function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input int i);
        longint unsigned a64, bytes, span, base, r;
        a64   = a;
        bytes = 64'd1 << size;
        r     = a64;
        if (burst == 2'b01) r = a64 + longint'(i) * bytes;
        else if (burst == 2'b10) begin
            span = (longint'(len) + 1) * bytes;
            base = a64 - (a64 % span);
            r    = base + ((a64 - base + longint'(i) * bytes) % span);
        end
        return r[31:0];
    endfunction

    function automatic bit is_illegal(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
        return (burst == 2'b11) || ((1 << size) > DW / 8) ||
               (burst == 2'b10 && len != 1 && len != 3 && len != 7 && len != 15);
    endfunction

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          stall;     // RREADY-low cycles per beat; -1 means random 0..3
        bit          exp_err;
        logic [31:0] exp_last;  // mem_addr of the final beat (OKAY bursts)
    } vec_t;

    task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, output bit ok);
        int t = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst; ARVALID = 1'b1;
        while (!ARREADY && t < 20) begin @(negedge clk); t++; end
        checks++;
        ok = ARREADY;
        if (!ok) begin
            errors++;
            $display("FAIL ar_handshake: ARREADY still 0 after %0d cycles, expected 1", t);
        end
        @(negedge clk);
        ARVALID = 1'b0;
    endtask

    // Junk on the AR channel mid-burst must be ignored.
    task automatic ar_noise();
        ARVALID = 1'($urandom_range(0, 1));
        ARID    = 4'($urandom);
        ARADDR  = $urandom;
        ARLEN   = 8'($urandom);
        ARBURST = 2'($urandom);
    endtask

    task automatic run_burst(input vec_t v, input bit chk_last);
        int c, n;
        bit ok;
        logic [31:0] ea, last_seen, exp_data;
        last_seen = '0;
        ar_send(v.id, v.addr, v.len, v.size, v.burst, ok);
        if (!ok) return;
        for (int b = 0; b <= int'(v.len); b++) begin
            ea = exp_addr(v.addr, v.len, v.size, v.burst, b);
            c  = 1;
            while (!RVALID && c < 10) begin
                if (v.exp_err) chk("err_mem_re", mem_re, 0);
                else begin
                    chk("mem_re", mem_re, c == 1);
                    if (c == 1) begin chk("mem_addr", mem_addr, ea); last_seen = mem_addr; end
                end
                ar_noise();
                @(negedge clk); c++;
            end
            checks++;
            if (!RVALID) begin
                errors++;
                $display("FAIL rvalid_timeout: RVALID still 0 on beat %0d, expected 1", b);
                ARVALID = 1'b0;
                return;
            end
            if (v.exp_err) chk("err_beat_gap", c, (b == 0) ? 1 : 2);
            else           chk("rvalid_latency", c, 3);
            exp_data = v.exp_err ? 32'h0 : memf(ea);
            n = (v.stall >= 0) ? v.stall : int'($urandom_range(0, 3));
            for (int s = 0; s <= n; s++) begin
                chk("rvalid_hold", RVALID, 1);
                chk("rid", RID, v.id);
                chk("rdata", RDATA, exp_data);
                chk("rresp", RRESP, v.exp_err ? 2'b10 : 2'b00);
                chk("rlast", RLAST, b == int'(v.len));
                chk("mem_re_idle", mem_re, 0);
                RREADY = (s == n);
                ar_noise();
                @(negedge clk);
            end
            RREADY = 1'b0;
        end
        ARVALID = 1'b0;
        chk("rvalid_after", RVALID, 0);
        chk("arready_after", ARREADY, 1);
        if (chk_last && !v.exp_err) chk("last_mem_addr", last_seen, v.exp_last);
    endtask

    task automatic wait_rvalid(output bit ok);
        int t = 0;
        while (!RVALID && t < 10) begin @(negedge clk); t++; end
        checks++;
        ok = RVALID;
        if (!ok) begin
            errors++;
            $display("FAIL wait_rvalid: RVALID still 0, expected 1");
        end
    endtask

    initial begin
        vec_t tbl[11];
        vec_t v;
        bit ok;
        int r;

        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0;
        ARVALID = 1'b0; RREADY = 1'b0;

        tbl[0]  = '{4'd3, 32'h0000_0100, 8'd0,   3'd2, 2'b01,  0, 1'b0, 32'h0000_0100};
        tbl[1]  = '{4'd1, 32'h0000_0040, 8'd3,   3'd2, 2'b01,  4, 1'b0, 32'h0000_004C};
        tbl[2]  = '{4'd2, 32'h0000_000C, 8'd3,   3'd2, 2'b10,  0, 1'b0, 32'h0000_0008};
        tbl[3]  = '{4'd4, 32'h0000_0020, 8'd2,   3'd2, 2'b00,  1, 1'b0, 32'h0000_0020};
        tbl[4]  = '{4'd5, 32'h0000_0020, 8'd2,   3'd2, 2'b11,  0, 1'b1, 32'h0};
        tbl[5]  = '{4'd6, 32'h0000_0020, 8'd2,   3'd2, 2'b10,  2, 1'b1, 32'h0};
        tbl[6]  = '{4'd7, 32'h0000_0020, 8'd2,   3'd3, 2'b01,  0, 1'b1, 32'h0};
        tbl[7]  = '{4'd8, 32'hFFFF_FFFC, 8'd1,   3'd2, 2'b01,  0, 1'b0, 32'h0000_0000};
        tbl[8]  = '{4'd9, 32'h0000_000D, 8'd3,   3'd2, 2'b10,  0, 1'b0, 32'h0000_0009};
        tbl[9]  = '{4'hA, 32'h0000_0031, 8'd15,  3'd0, 2'b10,  0, 1'b0, 32'h0000_0030};
        tbl[10] = '{4'hF, 32'h0000_1000, 8'd255, 3'd2, 2'b01,  0, 1'b0, 32'h0000_13FC};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_arready", ARREADY, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_rlast", RLAST, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_rid", RID, 0);
        chk("rst_rdata", RDATA, 0);
        chk("rst_rresp", RRESP, 0);
        chk("rst_mem_addr", mem_addr, 0);
        nrst = 1'b1;
        @(negedge clk);
        chk("arready_post_reset", ARREADY, 1);

        for (int i = 0; i < 11; i++) run_burst(tbl[i], 1'b1);

        // Mid-burst reset during the second beat of an 8-beat burst
        ar_send(4'd5, 32'h0000_0200, 8'd7, 3'd2, 2'b01, ok);
        wait_rvalid(ok);
        RREADY = 1'b1; @(negedge clk); RREADY = 1'b0;
        wait_rvalid(ok);
        nrst = 1'b0;
        #1;
        chk("midrst_rvalid", RVALID, 0);
        chk("midrst_mem_re", mem_re, 0);
        chk("midrst_arready", ARREADY, 0);
        @(negedge clk);
        nrst = 1'b1;
        RREADY = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("midrst_arready_release", ARREADY, 1);
            chk("midrst_no_rvalid", RVALID, 0);
            chk("midrst_no_mem_re", mem_re, 0);
        end
        RREADY = 1'b0;
        v = '{4'd6, 32'h0000_0300, 8'd0, 3'd2, 2'b01, 0, 1'b0, 32'h0000_0300};
        run_burst(v, 1'b1);

        // Randomized bursts against the model
        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 9));
            v.id    = 4'($urandom);
            v.addr  = $urandom;
            v.size  = 3'($urandom_range(0, 3));
            v.burst = 2'($urandom_range(0, 3));
            if (r < 6)      v.len = 8'($urandom_range(0, 7));
            else if (r < 8) v.len = 8'((1 << $urandom_range(1, 4)) - 1);
            else            v.len = 8'($urandom_range(0, 31));
            v.stall    = -1;
            v.exp_err  = is_illegal(v.len, v.size, v.burst);
            v.exp_last = '0;
            run_burst(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
